seg_scan_ctrl: RTL

Time-multiplexing scan controller for a multi-digit common-segment 7-segment display. Holds one DIGIT_W-bit code per digit and presents one code at a time on a single shared bus feeding the per-segment decoders (segment A..G logic). Drives a one-hot digit enable. Inserts blanking guard intervals between digits to prevent ghosting. Takes new display contents through a valid/ready load port. Commits new contents only at frame boundaries, so one frame never shows mixed old and new digits.

---
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-segment 7-segment display, with guard blanking and frame-aligned reloads.
// Optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN keeps leading zero digits dark (digit 0 is always lit).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 3,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          blank,
    output logic                          frame_tick
);
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = NUM_DIGITS * DIGIT_W;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [DATA_W-1:0]   active, active_next;
    logic [DATA_W-1:0]   pending, pending_next;
    logic                pending_full, pending_full_next;
    logic [DIGIT_W-1:0]  code_next;
    logic [NUM_DIGITS-1:0] en_next;
    logic                blank_next;
    logic                tick_next;
    logic                boundary;
    logic                lit;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero.
    assign lit = (idx == '0) || ((active >> (int'(idx) * DIGIT_W)) != '0);
`else
    assign lit = 1'b1;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next        = state;
        cnt_next          = cnt + 1'b1;
        idx_next          = idx;
        active_next       = active;
        pending_next      = pending;
        pending_full_next = pending_full;
        code_next         = digit_code;
        en_next           = digit_en;
        blank_next        = blank;
        boundary          = 1'b0;

        case (state)
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_next   = '0;
                    state_next = SHOW;
                    code_next  = active[int'(idx) * DIGIT_W +: DIGIT_W];
                    en_next    = lit ? (NUM_DIGITS'(1) << idx) : '0;
                    blank_next = 1'b0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_next   = '0;
                    state_next = GUARD;
                    blank_next = 1'b1;
                    en_next    = '0;
                    if (idx == IDX_LAST) begin
                        idx_next = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        tick_next = boundary;

        // Commit uses the pending state from before this edge; a same-edge load waits a frame.
        if (boundary && pending_full) begin
            active_next       = pending;
            pending_full_next = 1'b0;
        end
        if (load_valid && load_ready) begin
            pending_next      = load_data;
            pending_full_next = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GUARD;
            cnt          <= '0;
            idx          <= '0;
            // NOTE: the digit buffers are reset because a fresh frame must show all zeros.
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            load_ready   <= 1'b1;
            digit_code   <= '0;
            digit_en     <= '0;
            blank        <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            active       <= active_next;
            pending      <= pending_next;
            pending_full <= pending_full_next;
            load_ready   <= !pending_full_next;
            digit_code   <= code_next;
            digit_en     <= en_next;
            blank        <= blank_next;
            frame_tick   <= tick_next;
        end
    end
endmodule
